axi_fourchan_param_slave_buf: RTL and testbench

// - Parametrised slave-side AXI four-channel adapter between logic-link RX/TX FIFOs and the user AXI slave.
// - Unpacks AR/AW/W from rxfifo words and packs R/B into txfifo words.
// - Registers every channel through a skid buffer.
// - Limits outstanding reads and writes; reports counts and a sticky protocol error.

---
 rtl/axi_fourchan_param_slave_buf_pkg.sv | 39 +++
 rtl/axi_fourchan_param_slave_buf_if.sv | 100 ++++++++++
 rtl/axi_fourchan_param_slave_buf_skid.sv | 47 ++++
 rtl/axi_fourchan_param_slave_buf.sv | 109 ++++++++++
 tb/tb_axi_fourchan_param_slave_buf.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_fourchan_param_slave_buf_pkg.sv
// rtl/axi_fourchan_param_slave_buf_pkg.sv - packed link widths and AXI enums for the four-channel slave adapter
package axi_fourchan_slave_pkg;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'd0,
      BURST_INCR  = 2'd1,
      BURST_WRAP  = 2'd2,
      BURST_RSVD  = 2'd3
   } burst_e;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'd0,
      RESP_EXOKAY = 2'd1,
      RESP_SLVERR = 2'd2,
      RESP_DECERR = 2'd3
   } resp_e;

   // AR/AW word: {addr, burst, len, size, id} with id at the LSB
   function automatic int ar_w(input int id_w, input int addr_w);
      return id_w + 12 + addr_w;
   endfunction

   function automatic int w_w(input int id_w, input int data_w);
      return id_w + data_w + 1;
   endfunction

   function automatic int r_w(input int id_w, input int data_w);
      return id_w + data_w + 3;
   endfunction

   function automatic int b_w(input int id_w);
      return id_w + 2;
   endfunction

   function automatic int ax_addr_lsb(input int id_w);
      return id_w + 12;
   endfunction

endpackage

// File: rtl/axi_fourchan_param_slave_buf_if.sv
// rtl/axi_fourchan_param_slave_buf_if.sv - AXI slave side plus logic-link FIFO side signals of the adapter
interface axi_fourchan_param_slave_buf_if #(
   parameter int ID_W   = 4,
   parameter int ADDR_W = 48,
   parameter int DATA_W = 64
);
   import axi_fourchan_slave_pkg::*;

   localparam int AX_W = ar_w(ID_W, ADDR_W);
   localparam int W_W  = w_w(ID_W, DATA_W);
   localparam int R_W  = r_w(ID_W, DATA_W);
   localparam int B_W  = b_w(ID_W);

   logic [ID_W-1:0]   user_arid;
   logic [1:0]        user_arsize;
   logic [7:0]        user_arlen;
   logic [1:0]        user_arburst;
   logic [ADDR_W-1:0] user_araddr;
   logic              user_arvalid;
   logic              user_arready;

   logic [ID_W-1:0]   user_awid;
   logic [1:0]        user_awsize;
   logic [7:0]        user_awlen;
   logic [1:0]        user_awburst;
   logic [ADDR_W-1:0] user_awaddr;
   logic              user_awvalid;
   logic              user_awready;

   logic [ID_W-1:0]   user_wid;
   logic [DATA_W-1:0] user_wdata;
   logic              user_wlast;
   logic              user_wvalid;
   logic              user_wready;

   logic [ID_W-1:0]   user_rid;
   logic [DATA_W-1:0] user_rdata;
   logic              user_rlast;
   logic [1:0]        user_rresp;
   logic              user_rvalid;
   logic              user_rready;

   logic [ID_W-1:0]   user_bid;
   logic [1:0]        user_bresp;
   logic              user_bvalid;
   logic              user_bready;

   logic              user_ar_vld;
   logic [AX_W-1:0]   rxfifo_ar_data;
   logic              user_ar_ready;
   logic              user_aw_vld;
   logic [AX_W-1:0]   rxfifo_aw_data;
   logic              user_aw_ready;
   logic              user_w_vld;
   logic [W_W-1:0]    rxfifo_w_data;
   logic              user_w_ready;
   logic              user_r_vld;
   logic [R_W-1:0]    txfifo_r_data;
   logic              user_r_ready;
   logic              user_b_vld;
   logic [B_W-1:0]    txfifo_b_data;
   logic              user_b_ready;

   modport slave (
      output user_arid, user_arsize, user_arlen, user_arburst, user_araddr, user_arvalid,
      input  user_arready,
      output user_awid, user_awsize, user_awlen, user_awburst, user_awaddr, user_awvalid,
      input  user_awready,
      output user_wid, user_wdata, user_wlast, user_wvalid,
      input  user_wready,
      input  user_rid, user_rdata, user_rlast, user_rresp, user_rvalid,
      output user_rready,
      input  user_bid, user_bresp, user_bvalid,
      output user_bready,
      input  user_ar_vld, rxfifo_ar_data, output user_ar_ready,
      input  user_aw_vld, rxfifo_aw_data, output user_aw_ready,
      input  user_w_vld, rxfifo_w_data, output user_w_ready,
      output user_r_vld, txfifo_r_data, input user_r_ready,
      output user_b_vld, txfifo_b_data, input user_b_ready
   );

   modport master (
      input  user_arid, user_arsize, user_arlen, user_arburst, user_araddr, user_arvalid,
      output user_arready,
      input  user_awid, user_awsize, user_awlen, user_awburst, user_awaddr, user_awvalid,
      output user_awready,
      input  user_wid, user_wdata, user_wlast, user_wvalid,
      output user_wready,
      output user_rid, user_rdata, user_rlast, user_rresp, user_rvalid,
      input  user_rready,
      output user_bid, user_bresp, user_bvalid,
      input  user_bready,
      output user_ar_vld, rxfifo_ar_data, input user_ar_ready,
      output user_aw_vld, rxfifo_aw_data, input user_aw_ready,
      output user_w_vld, rxfifo_w_data, input user_w_ready,
      input  user_r_vld, txfifo_r_data, output user_r_ready,
      input  user_b_vld, txfifo_b_data, output user_b_ready
   );

endinterface

// File: rtl/axi_fourchan_param_slave_buf_skid.sv
// rtl/axi_fourchan_param_slave_buf_skid.sv - two-entry skid buffer with registered input ready
module llink_skid_buf #(
   parameter int WIDTH = 8
) (
   input  logic             clk_wr,
   input  logic             rst_wr,
   input  logic             in_vld,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_vld,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready
);
   logic             skid_vld;
   logic [WIDTH-1:0] skid_data;
   logic             in_fire;
   logic             load_out;

   assign in_fire  = in_vld & in_ready;
   assign load_out = out_ready | ~out_vld;

   // in_ready tracks "skid entry empty" one edge late, so it is a pure flop
   always_ff @(posedge clk_wr or posedge rst_wr) begin
      if (rst_wr) begin
         in_ready  <= 1'b0;
         out_vld   <= 1'b0;
         out_data  <= '0;
         skid_vld  <= 1'b0;
         skid_data <= '0;
      end else if (load_out) begin
         in_ready <= 1'b1;
         if (skid_vld) begin
            out_vld  <= 1'b1;
            out_data <= skid_data;
            skid_vld <= 1'b0;
         end else begin
            out_vld <= in_fire;
            if (in_fire) out_data <= in_data;
         end
      end else if (in_fire) begin
         skid_vld  <= 1'b1;
         skid_data <= in_data;
         in_ready  <= 1'b0;
      end
   end

endmodule

// File: rtl/axi_fourchan_param_slave_buf.sv
// rtl/axi_fourchan_param_slave_buf.sv - link FIFO to AXI slave adapter; LLINK_SLAVE_SKID_EN adds per-channel skid buffers
module axi_fourchan_param_slave_buf
   import axi_fourchan_slave_pkg::*;
#(
   parameter int ID_W       = 4,
   parameter int ADDR_W     = 48,
   parameter int DATA_W     = 64,
   parameter int MAX_RD_OUT = 8,
   parameter int MAX_WR_OUT = 8
) (
   input  logic                              clk_wr,
   input  logic                              rst_wr,
   axi_fourchan_param_slave_buf_if.slave     bus,
   output logic [$clog2(MAX_RD_OUT+1)-1:0]   rd_out_cnt,
   output logic [$clog2(MAX_WR_OUT+1)-1:0]   wr_out_cnt,
   output logic                              out_err
);
   localparam int AX_W = ar_w(ID_W, ADDR_W);
   localparam int W_W  = w_w(ID_W, DATA_W);
   localparam int R_W  = r_w(ID_W, DATA_W);
   localparam int B_W  = b_w(ID_W);
   localparam int RC_W = $clog2(MAX_RD_OUT+1);
   localparam int WC_W = $clog2(MAX_WR_OUT+1);
   localparam logic [RC_W-1:0] RD_MAX = RC_W'(MAX_RD_OUT);
   localparam logic [WC_W-1:0] WR_MAX = WC_W'(MAX_WR_OUT);

   logic            rd_ok, wr_ok;
   logic            ar_in_ready, aw_in_ready;
   logic [AX_W-1:0] ar_out, aw_out;
   logic [W_W-1:0]  w_out;
   logic [R_W-1:0]  r_in;
   logic [B_W-1:0]  b_in;
   logic            ar_pop, aw_pop, r_done, b_done;

   assign rd_ok = (rd_out_cnt != RD_MAX);
   assign wr_ok = (wr_out_cnt != WR_MAX);
   assign r_in  = {bus.user_rresp, bus.user_rlast, bus.user_rdata, bus.user_rid};
   assign b_in  = {bus.user_bresp, bus.user_bid};

`ifdef LLINK_SLAVE_SKID_EN
   // AR/AW valids are gated too, so the skid never takes a word the FIFO did not pop
   llink_skid_buf #(.WIDTH(AX_W)) u_ar_skid (
      .clk_wr, .rst_wr, .in_vld(bus.user_ar_vld & rd_ok), .in_data(bus.rxfifo_ar_data),
      .in_ready(ar_in_ready), .out_vld(bus.user_arvalid), .out_data(ar_out), .out_ready(bus.user_arready));
   llink_skid_buf #(.WIDTH(AX_W)) u_aw_skid (
      .clk_wr, .rst_wr, .in_vld(bus.user_aw_vld & wr_ok), .in_data(bus.rxfifo_aw_data),
      .in_ready(aw_in_ready), .out_vld(bus.user_awvalid), .out_data(aw_out), .out_ready(bus.user_awready));
   llink_skid_buf #(.WIDTH(W_W)) u_w_skid (
      .clk_wr, .rst_wr, .in_vld(bus.user_w_vld), .in_data(bus.rxfifo_w_data),
      .in_ready(bus.user_w_ready), .out_vld(bus.user_wvalid), .out_data(w_out), .out_ready(bus.user_wready));
   llink_skid_buf #(.WIDTH(R_W)) u_r_skid (
      .clk_wr, .rst_wr, .in_vld(bus.user_rvalid), .in_data(r_in),
      .in_ready(bus.user_rready), .out_vld(bus.user_r_vld), .out_data(bus.txfifo_r_data), .out_ready(bus.user_r_ready));
   llink_skid_buf #(.WIDTH(B_W)) u_b_skid (
      .clk_wr, .rst_wr, .in_vld(bus.user_bvalid), .in_data(b_in),
      .in_ready(bus.user_bready), .out_vld(bus.user_b_vld), .out_data(bus.txfifo_b_data), .out_ready(bus.user_b_ready));
`else
   assign bus.user_arvalid  = bus.user_ar_vld & rd_ok;
   assign ar_out            = bus.rxfifo_ar_data;
   assign ar_in_ready       = bus.user_arready;
   assign bus.user_awvalid  = bus.user_aw_vld & wr_ok;
   assign aw_out            = bus.rxfifo_aw_data;
   assign aw_in_ready       = bus.user_awready;
   assign bus.user_wvalid   = bus.user_w_vld;
   assign w_out             = bus.rxfifo_w_data;
   assign bus.user_w_ready  = bus.user_wready;
   assign bus.user_r_vld    = bus.user_rvalid;
   assign bus.txfifo_r_data = r_in;
   assign bus.user_rready   = bus.user_r_ready;
   assign bus.user_b_vld    = bus.user_bvalid;
   assign bus.txfifo_b_data = b_in;
   assign bus.user_bready   = bus.user_b_ready;
`endif

   assign bus.user_ar_ready = ar_in_ready & rd_ok;
   assign bus.user_aw_ready = aw_in_ready & wr_ok;

   assign {bus.user_araddr, bus.user_arburst, bus.user_arlen, bus.user_arsize, bus.user_arid} = ar_out;
   assign {bus.user_awaddr, bus.user_awburst, bus.user_awlen, bus.user_awsize, bus.user_awid} = aw_out;
   assign {bus.user_wlast, bus.user_wdata, bus.user_wid} = w_out;

   assign ar_pop = bus.user_ar_vld & bus.user_ar_ready;
   assign aw_pop = bus.user_aw_vld & bus.user_aw_ready;
   assign r_done = bus.user_r_vld & bus.user_r_ready & bus.txfifo_r_data[ID_W+DATA_W];
   assign b_done = bus.user_b_vld & bus.user_b_ready;

   // Increments cannot overflow: the pop itself is blocked at the maximum
   always_ff @(posedge clk_wr or posedge rst_wr) begin
      if (rst_wr) begin
         rd_out_cnt <= '0;
         wr_out_cnt <= '0;
         out_err    <= 1'b0;
      end else begin
         if (ar_pop && !r_done) begin
            rd_out_cnt <= rd_out_cnt + RC_W'(1);
         end else if (!ar_pop && r_done) begin
            if (rd_out_cnt == '0) out_err <= 1'b1;
            else                  rd_out_cnt <= rd_out_cnt - RC_W'(1);
         end
         if (aw_pop && !b_done) begin
            wr_out_cnt <= wr_out_cnt + WC_W'(1);
         end else if (!aw_pop && b_done) begin
            if (wr_out_cnt == '0) out_err <= 1'b1;
            else                  wr_out_cnt <= wr_out_cnt - WC_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_axi_fourchan_param_slave_buf.sv
// tb/tb_axi_fourchan_param_slave_buf.sv - directed self-checking bench for axi_fourchan_param_slave_buf
module tb_axi_fourchan_param_slave_buf;
   import axi_fourchan_slave_pkg::*;

   localparam int ID_W = 4, ADDR_W = 48, DATA_W = 64, MAX_RD_OUT = 8, MAX_WR_OUT = 8;
`ifdef LLINK_SLAVE_SKID_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 0;
`endif

   logic       clk_wr = 1'b0;
   logic       rst_wr = 1'b1;
   logic [3:0] rd_out_cnt, wr_out_cnt;
   logic       out_err;
   int         n_chk = 0, n_pass = 0;
   int         ar_pops = 0;

   always #5 clk_wr = ~clk_wr;

   axi_fourchan_param_slave_buf_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   axi_fourchan_param_slave_buf #(
      .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
      .MAX_RD_OUT(MAX_RD_OUT), .MAX_WR_OUT(MAX_WR_OUT)
   ) u_dut (
      .clk_wr(clk_wr), .rst_wr(rst_wr), .bus(bus),
      .rd_out_cnt(rd_out_cnt), .wr_out_cnt(wr_out_cnt), .out_err(out_err)
   );

   always @(negedge clk_wr)
      if (!rst_wr && bus.user_ar_vld && bus.user_ar_ready) ar_pops <= ar_pops + 1;

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic idle_inputs();
      bus.user_arready = 0; bus.user_awready = 0; bus.user_wready = 0;
      bus.user_rid = 0; bus.user_rdata = 0; bus.user_rlast = 0; bus.user_rresp = 0; bus.user_rvalid = 0;
      bus.user_bid = 0; bus.user_bresp = 0; bus.user_bvalid = 0;
      bus.user_ar_vld = 0; bus.rxfifo_ar_data = 0; bus.user_aw_vld = 0; bus.rxfifo_aw_data = 0;
      bus.user_w_vld = 0; bus.rxfifo_w_data = 0; bus.user_r_ready = 0; bus.user_b_ready = 0;
   endtask

   task automatic do_reset();
      @(posedge clk_wr); #1;
      rst_wr = 1; idle_inputs();
      repeat (2) @(posedge clk_wr);
      #1 rst_wr = 0;
      @(posedge clk_wr); #1;
   endtask

   task automatic send_ar(input logic [47:0] addr, input logic [3:0] id, input logic [7:0] len, output bit ok);
      bus.user_ar_vld = 1; bus.rxfifo_ar_data = {addr, 2'b01, len, 2'b11, id};
      ok = 0;
      for (int c = 0; c < 20 && !ok; c++) begin
         @(negedge clk_wr); ok = bus.user_ar_ready;
         @(posedge clk_wr); #1;
      end
      bus.user_ar_vld = 0;
   endtask

   task automatic send_aw(input logic [47:0] addr, input logic [3:0] id, output bit ok);
      bus.user_aw_vld = 1; bus.rxfifo_aw_data = {addr, 2'b01, 8'd0, 2'b11, id};
      ok = 0;
      for (int c = 0; c < 20 && !ok; c++) begin
         @(negedge clk_wr); ok = bus.user_aw_ready;
         @(posedge clk_wr); #1;
      end
      bus.user_aw_vld = 0;
   endtask

   task automatic send_w(input logic [63:0] data, input logic [3:0] id, input logic last, input int max_cyc);
      bit ok = 0;
      bus.user_w_vld = 1; bus.rxfifo_w_data = {last, data, id};
      for (int c = 0; c < max_cyc && !ok; c++) begin
         @(negedge clk_wr); ok = bus.user_w_ready;
         @(posedge clk_wr); #1;
      end
      bus.user_w_vld = 0;
   endtask

   task automatic send_w_burst(input int n, input logic [63:0] base);
      for (int k = 0; k < n; k++) begin
         bit ok = 0;
         bus.user_w_vld = 1; bus.rxfifo_w_data = {k == n - 1, base + 64'(k), 4'(k)};
         for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk_wr); ok = bus.user_w_ready;
            @(posedge clk_wr); #1;
         end
      end
      bus.user_w_vld = 0;
   endtask

   task automatic recv_w(input int n, input logic [63:0] base, input bit tog, output int span);
      int got = 0, first = 0, last = 0;
      bus.user_wready = 1;
      for (int cyc = 0; cyc < 100 && got < n; cyc++) begin
         @(negedge clk_wr);
         if (bus.user_wvalid && bus.user_wready) begin
            check_val("w_beat", 128'({bus.user_wlast, bus.user_wid, bus.user_wdata}),
                      128'({got == n - 1, 4'(got), base + 64'(got)}));
            if (got == 0) first = cyc;
            last = cyc;
            got++;
         end
         @(posedge clk_wr); #1;
         if (tog) bus.user_wready = ~bus.user_wready;
      end
      check_val("w_count", 128'(got), 128'(n));
      span = last - first;
   endtask

   task automatic send_r(input logic [3:0] id, input logic [63:0] data, input logic last);
      bit ok = 0;
      bus.user_rvalid = 1; bus.user_rid = id; bus.user_rdata = data; bus.user_rlast = last; bus.user_rresp = RESP_OKAY;
      for (int c = 0; c < 20 && !ok; c++) begin
         @(negedge clk_wr); ok = bus.user_rready;
         @(posedge clk_wr); #1;
      end
      bus.user_rvalid = 0;
   endtask

   task automatic send_b(input logic [3:0] id, input logic [1:0] resp);
      bit ok = 0;
      bus.user_bvalid = 1; bus.user_bid = id; bus.user_bresp = resp;
      for (int c = 0; c < 20 && !ok; c++) begin
         @(negedge clk_wr); ok = bus.user_bready;
         @(posedge clk_wr); #1;
      end
      bus.user_bvalid = 0;
   endtask

   task automatic wait_neg(input bit cond_is_b_fire, output int lat);
      lat = 0;
      @(negedge clk_wr);
      while (!(cond_is_b_fire ? (bus.user_b_vld && bus.user_b_ready) : bus.user_b_vld) && lat < 10) begin
         @(negedge clk_wr); lat++;
      end
   endtask

   initial begin
      bit ok;
      int lat, span, pops0, wv;
      idle_inputs();

      // reset values
      @(negedge clk_wr);
      check_val("rst_valids", 128'({bus.user_arvalid, bus.user_awvalid, bus.user_wvalid, bus.user_r_vld, bus.user_b_vld}), 128'(0));
      check_val("rst_readies", 128'({bus.user_ar_ready, bus.user_aw_ready, bus.user_w_ready, bus.user_rready, bus.user_bready}), 128'(0));
      check_val("rst_status", 128'({rd_out_cnt, wr_out_cnt, out_err}), 128'(0));
      check_val("rst_araddr", 128'(bus.user_araddr), 128'(0));
      do_reset();

      // single AR field unpack and latency
      bus.user_arready = 1;
      fork
         send_ar(48'h1234_5678_9ABC, 4'd3, 8'd7, ok);
         begin
            lat = 0;
            @(negedge clk_wr);
            while (!bus.user_arvalid && lat < 8) begin @(negedge clk_wr); lat++; end
            check_val("ar_latency", 128'(lat), 128'(LAT));
            check_val("ar_id", 128'(bus.user_arid), 128'(3));
            check_val("ar_len", 128'(bus.user_arlen), 128'(7));
            check_val("ar_addr", 128'(bus.user_araddr), 128'(48'h1234_5678_9ABC));
            check_val("ar_size_burst", 128'({bus.user_arsize, bus.user_arburst}), 128'({2'b11, BURST_INCR}));
         end
      join
      @(negedge clk_wr);
      check_val("rd_cnt_one", 128'(rd_out_cnt), 128'(1));

      // outstanding read limit
      do_reset();
      bus.user_arready = 1;
      for (int i = 0; i < 8; i++) begin
         send_ar(48'h1000 + 48'(i * 64), 4'(i), 8'd0, ok);
         check_val("ar_accept", 128'(ok), 128'(1));
      end
      bus.user_ar_vld = 1; bus.rxfifo_ar_data = {48'h2000, 2'b01, 8'd0, 2'b11, 4'd8};
      repeat (3) @(negedge clk_wr);
      check_val("ar_ready_gated", 128'(bus.user_ar_ready), 128'(0));
      check_val("rd_cnt_max", 128'(rd_out_cnt), 128'(8));
      @(posedge clk_wr); #1;
      pops0 = ar_pops;
      bus.user_r_ready = 1;
      fork
         send_r(4'd9, 64'hDEAD_BEEF_0000_0009, 1'b1);
         begin
            lat = 0;
            @(negedge clk_wr);
            while (!bus.user_r_vld && lat < 8) begin @(negedge clk_wr); lat++; end
            check_val("r_pack", 128'(bus.txfifo_r_data), 128'({2'b00, 1'b1, 64'hDEAD_BEEF_0000_0009, 4'd9}));
         end
      join
      repeat (4) @(negedge clk_wr);
      check_val("ar_ninth_pop", 128'(ar_pops - pops0), 128'(1));
      check_val("rd_cnt_back", 128'(rd_out_cnt), 128'(8));
      @(posedge clk_wr); #1 bus.user_ar_vld = 0;

      // W backpressure and throughput
      do_reset();
      fork
         send_w_burst(16, 64'h100);
         recv_w(16, 64'h100, 1'b1, span);
      join
      fork
         send_w_burst(8, 64'h200);
         recv_w(8, 64'h200, 1'b0, span);
      join
      check_val("w_no_bubble", 128'(span), 128'(7));

      // simultaneous AW pop and B push
      do_reset();
      bus.user_awready = 1;
      send_aw(48'h3000, 4'd1, ok);
      send_aw(48'h3040, 4'd2, ok);
      @(negedge clk_wr);
      check_val("wr_cnt_two", 128'(wr_out_cnt), 128'(2));
      @(posedge clk_wr); #1;
      fork
         send_b(4'd5, RESP_SLVERR);
         begin
            wait_neg(1'b0, lat);
            @(posedge clk_wr); #1;
            bus.user_aw_vld = 1; bus.rxfifo_aw_data = {48'h3080, 2'b01, 8'd0, 2'b11, 4'd3};
            bus.user_b_ready = 1;
            @(negedge clk_wr);
            check_val("aw_b_same_cycle", 128'({bus.user_aw_ready, bus.user_b_vld}), 128'(2'b11));
            check_val("b_pack", 128'(bus.txfifo_b_data), 128'({RESP_SLVERR, 4'd5}));
            @(posedge clk_wr); #1 bus.user_aw_vld = 0;
            @(negedge clk_wr);
            check_val("wr_cnt_stays", 128'({wr_out_cnt, out_err}), 128'({4'd2, 1'b0}));
         end
      join

      // B underflow sets sticky error
      do_reset();
      bus.user_b_ready = 1;
      fork
         send_b(4'd7, RESP_OKAY);
         begin
            wait_neg(1'b1, lat);
            check_val("err_before", 128'(out_err), 128'(0));
            @(negedge clk_wr);
            check_val("err_set", 128'({wr_out_cnt, out_err}), 128'({4'd0, 1'b1}));
         end
      join
      repeat (5) @(negedge clk_wr);
      check_val("err_sticky", 128'(out_err), 128'(1));
      @(posedge clk_wr); #1 rst_wr = 1;
      @(negedge clk_wr);
      check_val("err_cleared", 128'(out_err), 128'(0));

      // reset with buffered W beats and non-zero counts
      do_reset();
      bus.user_arready = 1; bus.user_awready = 1;
      for (int i = 0; i < 3; i++) send_ar(48'h4000 + 48'(i), 4'(i), 8'd0, ok);
      for (int i = 0; i < 5; i++) send_aw(48'h5000 + 48'(i), 4'(i), ok);
      @(negedge clk_wr);
      check_val("cnt_3_5", 128'({rd_out_cnt, wr_out_cnt}), 128'({4'd3, 4'd5}));
      @(posedge clk_wr); #1;
      bus.user_wready = 0;
      send_w(64'hAAAA, 4'd1, 1'b0, 3);
      send_w(64'hBBBB, 4'd2, 1'b1, 3);
      rst_wr = 1; bus.user_wready = 1;
      @(negedge clk_wr);
      check_val("rst_mid_valids", 128'({bus.user_arvalid, bus.user_awvalid, bus.user_wvalid, bus.user_r_vld, bus.user_b_vld}), 128'(0));
      check_val("rst_mid_cnts", 128'({rd_out_cnt, wr_out_cnt}), 128'(0));
      @(posedge clk_wr); #1 rst_wr = 0;
      wv = 0;
      repeat (6) begin
         @(negedge clk_wr);
         if (bus.user_wvalid) wv++;
      end
      check_val("no_stale_w", 128'(wv), 128'(0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
